// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (sign/zero/upper/branch) with a 2-entry valid/ready output buffer.
// Optional pop counter port xfer_cnt is enabled by defining IMM_EXT_CNT_EN.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
`ifdef IMM_EXT_CNT_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  localparam int EW = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext;

  always_comb begin
    sext = {{EW{in_data[IN_W-1]}}, in_data};
    case (in_mode)
      2'd0:    ext = sext;
      2'd1:    ext = {{EW{1'b0}}, in_data};
      2'd2:    ext = {in_data, {EW{1'b0}}};
      default: ext = {sext[OUT_W-3:0], 2'b00};
    endcase
  end

  logic [OUT_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic [1:0]       mode0_q, mode0_d, mode1_q, mode1_d;
  logic [1:0]       count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             push, pop;
  logic [1:0]       wr_idx;

  // Slot 0 is always the head; a pop shifts slot 1 down before the new entry lands.
  always_comb begin
    push       = in_valid && in_ready_q;
    pop        = (count_q != 2'd0) && out_ready;
    data0_d    = data0_q;
    data1_d    = data1_q;
    mode0_d    = mode0_q;
    mode1_d    = mode1_q;
    wr_idx     = count_q - {1'b0, pop};
    if (pop) begin
      data0_d = data1_q;
      mode0_d = mode1_q;
    end
    if (push) begin
      if (wr_idx == 2'd0) begin
        data0_d = ext;
        mode0_d = in_mode;
      end else begin
        data1_d = ext;
        mode1_d = in_mode;
      end
    end
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
    in_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data0_q    <= '0;
      data1_q    <= '0;
      mode0_q    <= '0;
      mode1_q    <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      mode0_q    <= mode0_d;
      mode1_q    <= mode1_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = out_valid ? data0_q : '0;
  assign out_mode  = out_valid ? mode0_q : '0;

`ifdef IMM_EXT_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q + {15'd0, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) xfer_cnt_q <= '0;
    else       xfer_cnt_q <= xfer_cnt_d;
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized handshake phase.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  out_mode;
`ifdef IMM_EXT_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_mode (out_mode)
`ifdef IMM_EXT_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  typedef struct {
    logic [31:0] d;
    logic [1:0]  m;
  } ent_t;

  ent_t        q[$];
  bit          rdy_m = 1'b0;
  logic [15:0] cnt_m = '0;

  function automatic logic [31:0] model_ext(input logic [15:0] d, input logic [1:0] m);
    longint u = longint'(d);
    longint s = (u >= 32768) ? u - 65536 : u;
    case (m)
      2'd0:    return 32'(s);
      2'd1:    return 32'(u);
      2'd2:    return 32'(u * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      rdy_m = 1'b0;
      cnt_m = '0;
    end else begin
      bit pu, po;
      pu = in_valid && rdy_m;
      po = (q.size() != 0) && out_ready;
      if (po) begin
        void'(q.pop_front());
        cnt_m = cnt_m + 16'd1;
      end
      if (pu) q.push_back('{model_ext(in_data, in_mode), in_mode});
      rdy_m = (q.size() != 2);
    end
  end

  always @(negedge clk) begin
    if (started && !reset) begin
      chk("model_out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("model_in_ready", 32'(in_ready), 32'(rdy_m));
      chk("model_out_data", out_data, (q.size() != 0) ? q[0].d : 32'd0);
      chk("model_out_mode", 32'(out_mode), (q.size() != 0) ? 32'(q[0].m) : 32'd0);
`ifdef IMM_EXT_CNT_EN
      chk("model_xfer_cnt", 32'(xfer_cnt), 32'(cnt_m));
`endif
    end
  end

  task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] m, input logic r);
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    out_ready = r;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) drive(1'b0, 16'h0, 2'd0, 1'b1);
  endtask

  initial begin
    logic [15:0] a, b, c;

    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_mode", 32'(out_mode), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    started = 1'b1;
    drive(1'b0, 16'h0, 2'd0, 1'b1);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Sign and zero modes, each result one cycle after its push.
    drive(1'b1, 16'd3782, 2'd0, 1'b1);
    chk("sign_pos", out_data, 32'h00000EC6);
    drive(1'b1, 16'hFFD5, 2'd0, 1'b1);
    chk("sign_neg", out_data, 32'hFFFFFFD5);
    drive(1'b1, 16'hFFD5, 2'd1, 1'b1);
    chk("zero_ext", out_data, 32'h0000FFD5);

    // Upper and branch modes.
    drive(1'b1, 16'h1234, 2'd2, 1'b1);
    chk("upper", out_data, 32'h12340000);
    chk("upper_mode", 32'(out_mode), 32'd2);
    drive(1'b1, 16'hFFFF, 2'd3, 1'b1);
    chk("branch_neg", out_data, 32'hFFFFFFFC);
    chk("branch_neg_mode", 32'(out_mode), 32'd3);
    drive(1'b1, 16'h0004, 2'd3, 1'b1);
    chk("branch_pos", out_data, 32'h00000010);
    chk("branch_pos_mode", 32'(out_mode), 32'd3);
    drain();
    chk("drained", 32'(out_valid), 32'd0);

    // Backpressure.
    a = 16'h0A0A; b = 16'hB0B0; c = 16'h0C0C;
    drive(1'b1, a, 2'd1, 1'b0);
    chk("bp_a_head", out_data, 32'h00000A0A);
    chk("bp_rdy_after_a", 32'(in_ready), 32'd1);
    drive(1'b1, b, 2'd1, 1'b0);
    chk("bp_full_rdy", 32'(in_ready), 32'd0);
    drive(1'b1, c, 2'd1, 1'b0);
    chk("bp_hold_a", out_data, 32'h00000A0A);
    chk("bp_still_full", 32'(in_ready), 32'd0);
    drive(1'b1, c, 2'd1, 1'b1);
    chk("bp_b_head", out_data, 32'h0000B0B0);
    chk("bp_rdy_back", 32'(in_ready), 32'd1);
    drive(1'b1, c, 2'd1, 1'b1);
    chk("bp_c_head", out_data, 32'h00000C0C);
    drive(1'b0, 16'h0, 2'd0, 1'b1);
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Simultaneous push and pop at count 1.
    drive(1'b1, 16'd100, 2'd1, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(100 + i), 2'd1, 1'b1);
      chk("pp_data", out_data, 32'(100 + i));
      chk("pp_rdy", 32'(in_ready), 32'd1);
    end
    drain();

    // Reset mid-operation with the buffer full.
    drive(1'b1, 16'h1111, 2'd0, 1'b0);
    drive(1'b1, 16'h2222, 2'd0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 16'h0, 2'd0, 1'b1);
    drive(1'b1, 16'h0055, 2'd1, 1'b0);
    chk("post_rst_new", out_data, 32'h00000055);
    drive(1'b0, 16'h0, 2'd0, 1'b1);
    chk("post_rst_empty", 32'(out_valid), 32'd0);

`ifdef IMM_EXT_CNT_EN
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 16'h0, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 16'(i), 2'd0, 1'b1);
    drive(1'b0, 16'h0, 2'd0, 1'b1);
    chk("cnt_five", 32'(xfer_cnt), 32'd5);
    force dut.xfer_cnt_q = 16'hFFFF;
    cnt_m = 16'hFFFF;
    #1 release dut.xfer_cnt_q;
    @(negedge clk);
    drive(1'b1, 16'h7, 2'd0, 1'b0);
    drive(1'b0, 16'h0, 2'd0, 1'b1);
    chk("cnt_wrap", 32'(xfer_cnt), 32'd0);
`endif

    // Randomized handshake traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom),
            1'($urandom_range(0, 2) != 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined successor to the fixed 16→32 sign extender used by the datapath's immediate path.
- Extends an IN_W-bit immediate to OUT_W bits in one of four modes selected per transaction.
- Results pass through a 2-entry valid/ready output buffer, so the decode stage can stall independently of execute.
- Sits between instruction decode and the ALU/branch-target operand mux.

Parameters:
- IN_W, 16, immediate input width; legal range IN_W ≥ 2.
- OUT_W, 32, extended output width; legal range OUT_W ≥ IN_W + 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer presents a valid immediate.
- in_ready  output  1  block can accept an immediate this cycle.
- in_data  input  IN_W  raw immediate.
- in_mode  input  2  extension mode: 0 sign, 1 zero, 2 upper, 3 branch.
- out_valid  output  1  out_data holds a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  OUT_W  extended result.
- out_mode  output  2  mode that travelled with out_data.

Behaviour:
- Clocking and reset: one clock domain (clk). reset is asynchronous and active-high. While reset is high:
  - buffer count = 0, out_valid = 0, in_ready = 0;
  - out_data = 0, out_mode = 0.
  - After reset deasserts, in_ready = 1 from the first clk edge onward.
- Extension is combinational on in_data at push time; the extended result is what gets stored.
  - mode 0 (sign): out = in_data replicated from bit IN_W-1 up to OUT_W.
  - mode 1 (zero): out = {(OUT_W-IN_W) zeros, in_data}.
  - mode 2 (upper): out = {in_data, (OUT_W-IN_W) zeros}.
  - mode 3 (branch): sign-extend to OUT_W, then shift left 2; the low 2 bits are 0 and the top 2 sign-extended bits are discarded.
- Handshake:
  - push when in_valid && in_ready; pop when out_valid && out_ready.
  - in_data and in_mode are only sampled on a push.
- Buffer: 2-entry FIFO of {data, mode}.
  - count is 0..2.
  - out_valid = (count != 0).
  - in_ready = (count != 2), driven from a register with no combinational path from out_ready.
  - out_data/out_mode show the head entry; they are 0 when empty.
- Latency: a push at edge N is visible on out_data after edge N (one cycle) when the buffer was empty. When the buffer was non-empty, the result appears after the older entries pop.
- Throughput: one transaction per cycle is sustained with out_ready held at 1.
- Boundaries:
  - Push and pop in the same cycle with count = 1: count stays 1, head advances to the new entry.
  - Push and pop in the same cycle with count = 2: impossible, since in_ready = 0.
  - Pop with count = 2 and no push: count becomes 1 and in_ready rises next cycle.
  - Push while full: ignored, because in_ready = 0 blocks it.
  - Pop while empty: ignored, because out_valid = 0.
  - out_data/out_mode must remain stable while out_valid && !out_ready.
  - Reset mid-operation flushes all entries immediately (asynchronous); no pending result survives.
  - Order is strictly FIFO.

Optional Feature:
- Macro: IMM_EXT_CNT_EN.
- When defined:
  - adds output port xfer_cnt (16 bits), a count of pops;
  - it is reset to 0 and wraps from 0xFFFF to 0x0000.
- When undefined:
  - the port and counter do not exist;
  - all other behaviour is identical.

Test Plan (IN_W=16, OUT_W=32):
- Sign and zero modes: out_ready=1; push 3782 with mode 0, then 0xFFD5 (-43) with mode 0, then 0xFFD5 with mode 1 → out_data 0x00000EC6, 0xFFFFFFD5, 0x0000FFD5 on consecutive cycles, each one cycle after its push.
- Upper and branch modes: push 0x1234 with mode 2, 0xFFFF with mode 3, 0x0004 with mode 3 → 0x12340000, 0xFFFFFFFC, 0x00000010; out_mode echoes 2, 3, 3.
- Backpressure: out_ready=0; offer 3 values A, B, C back-to-back.
  - Required: A and B are accepted; in_ready=0 on the third cycle; out_data holds A stable.
  - Then raise out_ready: A, B, C emerge in order, and C is accepted the cycle after in_ready returns.
- Simultaneous push and pop: hold count=1 with in_valid=1 and out_ready=1 for 8 cycles → 8 results, one per cycle, count stays 1, in_ready stays 1.
- Reset mid-operation: buffer full, assert reset between edges → out_valid=0, in_ready=0, out_data=0 immediately. After release, the first push yields only the new value.
- With IMM_EXT_CNT_EN defined:
  - After 5 pops, xfer_cnt = 5.
  - Force the counter to 0xFFFF, then one pop → xfer_cnt = 0x0000.
